mem_port_arb: RTL and testbench

- Arbiter and sequencer for the single data-memory port shared by instruction fetch (IF) and the memory stage (M: loads/stores).
- Accepts one request at a time, drives it to the memory bus with a valid/ready handshake, and waits for the response.
- Returns the read data to the owning requester and raises per-requester stall signals for the pipeline controller.
- M has priority over IF; a starvation counter guarantees IF progress.

---
 rtl/mem_port_arb_pkg.sv | 22 ++
 rtl/mem_port_arb_starve_cnt.sv | 40 ++++
 rtl/mem_port_arb.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arb.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM state encoding,
// owner codes and a width helper for the starvation counter.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } arb_owner_e;

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arb_starve_cnt.sv
// Saturating up-counter with synchronous clear; sat_o flags that the
// counter has reached MAX. Clear has priority over increment.
module mem_port_arb_starve_cnt
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int unsigned W = cnt_width(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_port_arb.sv
// Arbiter/sequencer for the single data-memory port shared by instruction
// fetch (IF) and the memory stage (M). One transaction in flight at a time.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req_valid,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_ready,
  output logic                mem_rvalid,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wmask,
  input  logic                bus_rsp_valid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int unsigned MASK_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [MASK_W-1:0] bus_wmask_q, bus_wmask_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              mem_rvalid_q, mem_rvalid_d;

  logic idle;
  logic grant_mem;
  logic grant_if;
  logic starve_sat;

  // Grants are combinational from IDLE; qualified by rst so nothing pulses during reset.
  assign idle      = rst && (state_q == ARB_IDLE);
  assign grant_mem = idle && mem_req_valid && !(if_req_valid && starve_sat);
  assign grant_if  = idle && if_req_valid && !grant_mem;

  mem_port_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (grant_mem && if_req_valid),
    .clr_i (grant_if || (idle && !if_req_valid)),
    .sat_o (starve_sat)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wmask_d  = bus_wmask_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_rvalid_d  = 1'b0;
    mem_rvalid_d = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_mem) begin
          state_d     = ARB_REQ;
          owner_d     = OWN_MEM;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          bus_wmask_d = mem_we ? mem_wmask : '0;
        end else if (grant_if) begin
          state_d     = ARB_REQ;
          owner_d     = OWN_IF;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          bus_wmask_d = '0;
        end
      end
      ARB_REQ: begin
        if (bus_req_ready) begin
          state_d = ARB_RSP;
        end
      end
      ARB_RSP: begin
        // Response data lands in the owner's register; a store completes with zero data.
        if (bus_rsp_valid) begin
          state_d = ARB_IDLE;
          owner_d = OWN_NONE;
          if (owner_q == OWN_IF) begin
            if_rdata_d  = bus_rdata;
            if_rvalid_d = 1'b1;
          end else if (owner_q == OWN_MEM) begin
            mem_rdata_d  = bus_we_q ? '0 : bus_rdata;
            mem_rvalid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_NONE;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wmask_q  <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_rvalid_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wmask_q  <= bus_wmask_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_rvalid_q  <= if_rvalid_d;
      mem_rvalid_q <= mem_rvalid_d;
    end
  end

  assign if_ready      = grant_if;
  assign mem_ready     = grant_mem;
  assign if_rvalid     = if_rvalid_q;
  assign mem_rvalid    = mem_rvalid_q;
  assign if_rdata      = if_rdata_q;
  assign mem_rdata     = mem_rdata_q;
  assign bus_req_valid = (state_q == ARB_REQ);
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wmask     = bus_wmask_q;

  // A requester stalls while waiting for a grant and while its transaction is in flight.
  assign stall_if  = rst && ((if_req_valid && !grant_if) ||
                             ((state_q != ARB_IDLE) && (owner_q == OWN_IF)));
  assign stall_mem = rst && ((mem_req_valid && !grant_mem) ||
                             ((state_q != ARB_IDLE) && (owner_q == OWN_MEM)));

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_mem_port_arb;

  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid;
  logic [63:0]       if_addr;
  logic              if_ready, if_rvalid;
  logic [63:0]       if_rdata;
  logic              mem_req_valid, mem_we;
  logic [63:0]       mem_addr, mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_ready, mem_rvalid;
  logic [63:0]       mem_rdata;
  logic              bus_req_valid, bus_req_ready, bus_we;
  logic [63:0]       bus_addr, bus_wdata;
  logic [7:0]        bus_wmask;
  logic              bus_rsp_valid;
  logic [63:0]       bus_rdata;
  logic              stall_if, stall_mem;

  always #5 clk = ~clk;

  mem_port_arb #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_addr       (if_addr),
    .if_ready      (if_ready),
    .if_rvalid     (if_rvalid),
    .if_rdata      (if_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_ready     (mem_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_wmask     (bus_wmask),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata),
    .stall_if      (stall_if),
    .stall_mem     (stall_mem)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Snapshot of DUT outputs taken at the falling edge of the current cycle.
  typedef struct {
    logic        if_ready, mem_ready, if_rvalid, mem_rvalid;
    logic        stall_if, stall_mem, bus_req_valid, bus_we;
    logic [63:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic [7:0]  bus_wmask;
  } snap_t;
  snap_t s;

  // Transaction-level model: one request in flight, owner 0=none 1=IF 2=M.
  bit          m_busy, m_sent, m_if_rv, m_mem_rv;
  int          m_owner, m_cnt;
  logic        m_we;
  logic [63:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;
  logic [7:0]  m_wmask;

  task automatic model_reset();
    m_busy = 0; m_sent = 0; m_if_rv = 0; m_mem_rv = 0;
    m_owner = 0; m_cnt = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_wmask = '0;
    m_if_rdata = '0; m_mem_rdata = '0;
  endtask

  // One clock cycle: inputs already applied; sample, compare, advance model, move past the edge.
  task automatic step();
    logic idle, g_m, g_i;
    @(negedge clk);
    s.if_ready = if_ready;   s.mem_ready = mem_ready;
    s.if_rvalid = if_rvalid; s.mem_rvalid = mem_rvalid;
    s.stall_if = stall_if;   s.stall_mem = stall_mem;
    s.bus_req_valid = bus_req_valid; s.bus_we = bus_we;
    s.if_rdata = if_rdata;   s.mem_rdata = mem_rdata;
    s.bus_addr = bus_addr;   s.bus_wdata = bus_wdata; s.bus_wmask = bus_wmask;
    if (!rst) model_reset();
    idle = rst && !m_busy;
    g_m  = idle && mem_req_valid && !(if_req_valid && (m_cnt >= STARVE_MAX));
    g_i  = idle && if_req_valid && !g_m;
    check("if_ready",      64'(s.if_ready),      64'(g_i));
    check("mem_ready",     64'(s.mem_ready),     64'(g_m));
    check("if_rvalid",     64'(s.if_rvalid),     64'(m_if_rv));
    check("mem_rvalid",    64'(s.mem_rvalid),    64'(m_mem_rv));
    check("if_rdata",      s.if_rdata,           m_if_rdata);
    check("mem_rdata",     s.mem_rdata,          m_mem_rdata);
    check("bus_req_valid", 64'(s.bus_req_valid), 64'(m_busy && !m_sent));
    check("bus_we",        64'(s.bus_we),        64'(m_we));
    check("bus_addr",      s.bus_addr,           m_addr);
    check("bus_wdata",     s.bus_wdata,          m_wdata);
    check("bus_wmask",     64'(s.bus_wmask),     64'(m_wmask));
    check("stall_if",  64'(s.stall_if),
          64'(rst && ((if_req_valid && !g_i) || (m_busy && m_owner == 1))));
    check("stall_mem", 64'(s.stall_mem),
          64'(rst && ((mem_req_valid && !g_m) || (m_busy && m_owner == 2))));
    m_if_rv = 0; m_mem_rv = 0;
    if (rst) begin
      if (g_m) begin
        m_busy = 1; m_sent = 0; m_owner = 2;
        m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
        m_wmask = mem_we ? mem_wmask : 8'h00;
        m_cnt = !if_req_valid ? 0 : (m_cnt < STARVE_MAX ? m_cnt + 1 : m_cnt);
      end else if (g_i) begin
        m_busy = 1; m_sent = 0; m_owner = 1;
        m_we = 0; m_addr = if_addr; m_wdata = '0; m_wmask = '0;
        m_cnt = 0;
      end else if (idle) begin
        m_cnt = 0;
      end else if (!m_sent) begin
        if (bus_req_ready) m_sent = 1;
      end else if (bus_rsp_valid) begin
        m_busy = 0; m_sent = 0;
        if (m_owner == 1) begin
          m_if_rv = 1; m_if_rdata = bus_rdata;
        end else begin
          m_mem_rv = 1; m_mem_rdata = m_we ? 64'h0 : bus_rdata;
        end
        m_owner = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_valid = 0; if_addr = '0;
    mem_req_valid = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    step();
    step();
    rst = 1;
    step();
  endtask

  int m_since;
  int if_gap_q[$];

  initial begin
    rst = 0;
    clear_inputs();
    model_reset();
    step();
    check("reset_bus_req_valid", 64'(s.bus_req_valid), 64'h0);
    check("reset_if_rdata", s.if_rdata, 64'h0);
    step();
    rst = 1;
    step();

    // IF-only read with minimum latency.
    if_req_valid = 1; if_addr = 64'h8000_0000; bus_req_ready = 1;
    step();
    check("t1_if_ready_T", 64'(s.if_ready), 64'h1);
    if_req_valid = 0;
    step();
    check("t1_bus_addr", s.bus_addr, 64'h8000_0000);
    check("t1_bus_wmask", 64'(s.bus_wmask), 64'h0);
    bus_rsp_valid = 1; bus_rdata = 64'h0000_0013;
    step();
    bus_rsp_valid = 0;
    step();
    check("t1_if_rvalid_T3", 64'(s.if_rvalid), 64'h1);
    check("t1_if_rdata", s.if_rdata, 64'h13);
    check("t1_stall_if_T3", 64'(s.stall_if), 64'h0);
    step();
    check("t1_rdata_hold", s.if_rdata, 64'h13);

    // M store.
    mem_req_valid = 1; mem_we = 1; mem_addr = 64'h8000_1000;
    mem_wdata = 64'hDEAD_BEEF; mem_wmask = 8'h0F;
    step();
    check("t2_mem_ready", 64'(s.mem_ready), 64'h1);
    mem_req_valid = 0;
    step();
    check("t2_bus_we", 64'(s.bus_we), 64'h1);
    check("t2_bus_addr", s.bus_addr, 64'h8000_1000);
    check("t2_bus_wdata", s.bus_wdata, 64'hDEAD_BEEF);
    check("t2_bus_wmask", 64'(s.bus_wmask), 64'h0F);
    bus_rsp_valid = 1; bus_rdata = 64'h1234_5678_9ABC_DEF0;
    step();
    bus_rsp_valid = 0;
    step();
    check("t2_mem_rvalid", 64'(s.mem_rvalid), 64'h1);
    check("t2_mem_rdata_store", s.mem_rdata, 64'h0);

    // Simultaneous requests: M first, IF granted on M's completion cycle.
    if_req_valid = 1; if_addr = 64'h8000_0004;
    mem_req_valid = 1; mem_we = 0; mem_addr = 64'h8000_2000;
    step();
    check("t3_mem_ready", 64'(s.mem_ready), 64'h1);
    check("t3_if_ready_lose", 64'(s.if_ready), 64'h0);
    check("t3_stall_if", 64'(s.stall_if), 64'h1);
    mem_req_valid = 0;
    step();
    bus_rsp_valid = 1; bus_rdata = 64'hA5A5;
    step();
    bus_rsp_valid = 0;
    step();
    check("t3_mem_rvalid", 64'(s.mem_rvalid), 64'h1);
    check("t3_if_ready_on_cmpl", 64'(s.if_ready), 64'h1);
    if_req_valid = 0;
    step();
    bus_rsp_valid = 1; bus_rdata = 64'h77;
    step();
    bus_rsp_valid = 0;
    step();
    check("t3_if_rdata", s.if_rdata, 64'h77);

    // Starvation: M back-to-back, IF held; expect 4 M grants per IF grant.
    do_reset();
    if_req_valid = 1; if_addr = 64'h8000_0100;
    mem_req_valid = 1; mem_we = 0; mem_addr = 64'h8000_3000;
    bus_req_ready = 1; bus_rsp_valid = 1; bus_rdata = 64'h55;
    m_since = 0;
    for (int c = 0; c < 60 && if_gap_q.size() < 2; c++) begin
      step();
      if (s.mem_ready) m_since++;
      if (s.if_ready) begin
        if_gap_q.push_back(m_since);
        m_since = 0;
      end
    end
    check("t4_if_grants_seen", 64'(if_gap_q.size()), 64'd2);
    if (if_gap_q.size() == 2) begin
      check("t4_m_before_if_1", 64'(if_gap_q[0]), 64'd4);
      check("t4_m_before_if_2", 64'(if_gap_q[1]), 64'd4);
    end
    if_req_valid = 0; mem_req_valid = 0;
    for (int c = 0; c < 4; c++) step();
    bus_rsp_valid = 0;

    // Bus backpressure: ready low for 5 cycles with an M load in flight.
    do_reset();
    mem_req_valid = 1; mem_we = 0; mem_addr = 64'h1234_5678; mem_wdata = 64'h99;
    bus_req_ready = 0;
    step();
    check("t5_mem_ready", 64'(s.mem_ready), 64'h1);
    mem_req_valid = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("t5_bus_req_valid", 64'(s.bus_req_valid), 64'h1);
      check("t5_bus_addr", s.bus_addr, 64'h1234_5678);
      check("t5_stall_mem", 64'(s.stall_mem), 64'h1);
      check("t5_no_rvalid", 64'(s.mem_rvalid), 64'h0);
    end
    bus_req_ready = 1;
    step();
    bus_req_ready = 0; bus_rsp_valid = 1; bus_rdata = 64'hCAFE;
    step();
    bus_rsp_valid = 0;
    step();
    check("t5_mem_rvalid", 64'(s.mem_rvalid), 64'h1);
    check("t5_mem_rdata", s.mem_rdata, 64'hCAFE);

    // Reset during RSP: transaction abandoned, late response ignored.
    if_req_valid = 1; if_addr = 64'h8000_0040; bus_req_ready = 1;
    step();
    if_req_valid = 0;
    step();
    rst = 0;
    step();
    check("t6_rst_stall_if", 64'(s.stall_if), 64'h0);
    check("t6_rst_bus_addr", s.bus_addr, 64'h0);
    check("t6_rst_mem_rdata", s.mem_rdata, 64'h0);
    rst = 1; bus_rsp_valid = 1; bus_rdata = 64'hBAD;
    step();
    bus_rsp_valid = 0;
    step();
    check("t6_no_rvalid", 64'(s.if_rvalid), 64'h0);
    if_req_valid = 1; if_addr = 64'h8000_0080;
    step();
    check("t6_regrant", 64'(s.if_ready), 64'h1);
    if_req_valid = 0;
    step();
    bus_rsp_valid = 1; bus_rdata = 64'h2222;
    step();
    bus_rsp_valid = 0;
    step();
    check("t6_rvalid_after", 64'(s.if_rvalid), 64'h1);
    bus_req_ready = 0;

    // Randomized traffic, including stray bus responses and occasional reset.
    for (int c = 0; c < 2000; c++) begin
      if (s.if_ready) if_req_valid = 0;
      if (s.mem_ready) mem_req_valid = 0;
      rst = ($urandom_range(0, 299) != 0);
      if (!if_req_valid && ($urandom_range(0, 99) < 35)) begin
        if_req_valid = 1;
        if_addr = {$urandom, $urandom};
      end
      if (!mem_req_valid && ($urandom_range(0, 99) < 35)) begin
        mem_req_valid = 1;
        mem_we    = 1'($urandom_range(0, 1));
        mem_addr  = {$urandom, $urandom};
        mem_wdata = {$urandom, $urandom};
        mem_wmask = 8'($urandom);
      end
      bus_req_ready = ($urandom_range(0, 99) < 60);
      bus_rsp_valid = ($urandom_range(0, 99) < 40);
      bus_rdata     = {$urandom, $urandom};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
